// File: rtl/icap_reg_reader_if.sv
// Request/status bundle between firmware-side logic and icap_reg_reader.
//   start    : single-cycle read request (master -> slave)
//   reg_addr : 6-bit configuration register address (master -> slave)
//   busy     : transaction in progress (slave -> master)
//   done     : one-cycle completion pulse (slave -> master)
//   error    : READ timed out, valid with done (slave -> master)
//   rd_data  : captured register value, normal bit order (slave -> master)
interface icap_reg_reader_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;

    logic              start;
    logic [ADDR_W-1:0] reg_addr;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, reg_addr,
        input  busy, done, error, rd_data
    );

    modport slave (
        input  start, reg_addr,
        output busy, done, error, rd_data
    );
endinterface

// File: rtl/icap_reg_reader.sv
// Reads one 16-bit Spartan-6 configuration register through an external ICAP:
// sync, Type-1 read header, wait for BUSY low, capture O, then always desync.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request/status interface (slave side)
//   icap_ce    : ICAP CE (active-low), registered
//   icap_wr    : ICAP WRITE (0 = write, 1 = read), registered
//   icap_i     : ICAP I, registered, bit-reversed within each byte
//   icap_o     : ICAP O, bit-reversed within each byte
//   icap_busy  : ICAP BUSY
module icap_reg_reader #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    icap_reg_reader_if.slave       req,
    output logic                   icap_ce,
    output logic                   icap_wr,
    output logic [15:0]            icap_i,
    input  logic [15:0]            icap_o,
    input  logic                   icap_busy
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] W_DUMMY  = 16'hFFFF;
    localparam logic [DATA_W-1:0] W_SYNC_H = 16'hAA99;
    localparam logic [DATA_W-1:0] W_SYNC_L = 16'h5566;
    localparam logic [DATA_W-1:0] W_NOOP   = 16'h2000;
    localparam logic [DATA_W-1:0] W_CMD    = 16'h30A1;
    localparam logic [DATA_W-1:0] W_DESYNC = 16'h000D;

    typedef enum logic [3:0] {
        IDLE, DUMMY, SYNC_H, SYNC_L, NOOP_A, RDHDR, NOOP_B, NOOP_C,
        TURN_R, READ, TURN_W, CMD, DESYNC, NOOP_D, NOOP_E, DONE
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    rd_cnt, cnt_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic                tmo_q, tmo_nx;
    logic [DATA_W-1:0]   o_q;
    logic                busy_q;
    logic                busy_nx, done_nx, err_nx;
    logic [DATA_W-1:0]   rd_nx;
    logic                ce_nx, wr_nx;
    logic [DATA_W-1:0]   din_nx;

    // ICAP data pins carry each byte MSB-first; the same swap maps both ways.
    function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b]     = w[7-b];
            r[8 + b] = w[15-b];
        end
        return r;
    endfunction

    // State, request/status and ICAP output registers; ICAP inputs sampled every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            addr_q      <= '0;
            tmo_q       <= 1'b0;
            o_q         <= '0;
            busy_q      <= 1'b0;
            req.busy    <= 1'b0;
            req.done    <= 1'b0;
            req.error   <= 1'b0;
            req.rd_data <= '0;
            icap_ce     <= 1'b1;
            icap_wr     <= 1'b1;
            icap_i      <= 16'hFFFF;
        end else begin
            state       <= state_nx;
            rd_cnt      <= cnt_nx;
            addr_q      <= addr_nx;
            tmo_q       <= tmo_nx;
            o_q         <= icap_o;
            busy_q      <= icap_busy;
            req.busy    <= busy_nx;
            req.done    <= done_nx;
            req.error   <= err_nx;
            req.rd_data <= rd_nx;
            icap_ce     <= ce_nx;
            icap_wr     <= wr_nx;
            icap_i      <= byte_rev(din_nx);
        end
    end

    // Next state, next ICAP pin values and status updates.
    always_comb begin
        state_nx = state;
        cnt_nx   = rd_cnt;
        addr_nx  = addr_q;
        tmo_nx   = tmo_q;
        rd_nx    = req.rd_data;
        err_nx   = req.error;
        busy_nx  = (state != IDLE);
        done_nx  = (state == DONE);
        ce_nx    = 1'b1;
        wr_nx    = 1'b1;
        din_nx   = W_DUMMY;

        case (state)
            IDLE: begin
                if (req.start) begin
                    state_nx = DUMMY;
                    addr_nx  = req.reg_addr;
                    err_nx   = 1'b0;
                    tmo_nx   = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            DUMMY:  begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_DUMMY;  state_nx = SYNC_H; end
            SYNC_H: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_SYNC_H; state_nx = SYNC_L; end
            SYNC_L: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_SYNC_L; state_nx = NOOP_A; end
            NOOP_A: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_NOOP;   state_nx = RDHDR;  end
            RDHDR: begin
                // Type-1 packet, read opcode, one word.
                ce_nx    = 1'b0;
                wr_nx    = 1'b0;
                din_nx   = {3'b001, 2'b01, addr_q, 5'd1};
                state_nx = NOOP_B;
            end
            NOOP_B: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_NOOP; state_nx = NOOP_C; end
            NOOP_C: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_NOOP; state_nx = TURN_R; end
            TURN_R: begin
                cnt_nx   = '0;
                state_nx = READ;
            end
            READ: begin
                // First three cycles are ignored: O is not valid before the read pipeline fills.
                ce_nx = 1'b0;
                wr_nx = 1'b1;
                if (rd_cnt >= CNT_W'(3) && !busy_q) begin
                    rd_nx    = byte_rev(o_q);
                    cnt_nx   = '0;
                    state_nx = TURN_W;
                end else if (rd_cnt == CNT_W'(TIMEOUT)) begin
                    tmo_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = TURN_W;
                end else begin
                    cnt_nx = rd_cnt + CNT_W'(1);
                end
            end
            TURN_W: begin ce_nx = 1'b1; wr_nx = 1'b0; state_nx = CMD; end
            // Desync runs even after a timeout so the config logic is never left synced.
            CMD:    begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_CMD;    state_nx = DESYNC; end
            DESYNC: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_DESYNC; state_nx = NOOP_D; end
            NOOP_D: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_NOOP;   state_nx = NOOP_E; end
            NOOP_E: begin ce_nx = 1'b0; wr_nx = 1'b0; din_nx = W_NOOP;   state_nx = DONE;   end
            DONE: begin
                err_nx   = tmo_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
